centroid_updater: RTL and testbench

Downstream neighbour of the distance comparator in the K-means datapath. Consumes each data point together with its one-hot closest-cluster vector and accumulates per-cluster coordinate sums and point counts over one epoch. On an epoch-end strobe it divides each sum by its count using a shared sequential divider, then streams the N new centroids out over a valid/ready handshake for reload into the distance stage.

---
 rtl/kmeans_pkg.sv | 40 ++++
 rtl/centroid_updater_if.sv | 33 +++
 rtl/seq_divider.sv | 68 ++++++
 rtl/centroid_updater.sv | 147 ++++++++++++++
 tb/tb_centroid_updater.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/kmeans_pkg.sv
// Shared K-means datapath constants, FSM encoding and one-hot helpers.
// Latency: n/a. Backpressure: n/a.
// Used by the centroid updater and the later mean/variance stages.
package kmeans_pkg;

    localparam int N_CORES = 16;
    localparam int COORD_W = 8;
    localparam int CNT_W   = 16;
    localparam int SUM_W   = COORD_W + CNT_W;
    localparam int IDX_W   = $clog2(N_CORES);

    typedef enum logic [2:0] {
        ACCUM = 3'd0,
        LOAD  = 3'd1,
        DIV_X = 3'd2,
        DIV_Y = 3'd3,
        EMIT  = 3'd4,
        CLEAR = 3'd5
    } state_e;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic               empty;
    } cen_t;

    function automatic logic onehot_ok(input logic [N_CORES-1:0] v);
        return (v != '0) && ((v & (v - N_CORES'(1))) == '0);
    endfunction

    function automatic logic [IDX_W-1:0] onehot_enc(input logic [N_CORES-1:0] v);
        logic [IDX_W-1:0] r;
        r = '0;
        for (int i = 0; i < N_CORES; i++) begin
            if (v[i]) r = r | IDX_W'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/centroid_updater_if.sv
// Point-in / centroid-out bus of the centroid updater.
// Latency: n/a. Backpressure: pointValid/pointReady in, cenValid/cenReady out.
// slave = the updater, master = the comparator/reload side.
interface centroid_updater_if;
    import kmeans_pkg::*;

    logic                 pointValid;
    logic                 pointReady;
    logic [COORD_W-1:0]   pointX;
    logic [COORD_W-1:0]   pointY;
    logic [N_CORES-1:0]   closestCore;
    logic                 epochEnd;
    logic                 cenValid;
    logic                 cenReady;
    logic [IDX_W-1:0]     cenIdx;
    logic [COORD_W-1:0]   cenX;
    logic [COORD_W-1:0]   cenY;
    logic                 cenEmpty;
    logic                 busy;
    logic                 errOneHot;
    logic                 errOvf;

    modport slave (
        input  pointValid, pointX, pointY, closestCore, epochEnd, cenReady,
        output pointReady, cenValid, cenIdx, cenX, cenY, cenEmpty, busy, errOneHot, errOvf
    );

    modport master (
        output pointValid, pointX, pointY, closestCore, epochEnd, cenReady,
        input  pointReady, cenValid, cenIdx, cenX, cenY, cenEmpty, busy, errOneHot, errOvf
    );

endinterface

// File: rtl/seq_divider.sv
// Restoring unsigned divider, one quotient bit per cycle, floor result.
// Latency: start in cycle t, done pulses and quotient valid in cycle t+QUOT_W.
// Backpressure: none; quotient holds until the next start.
module seq_divider import kmeans_pkg::*; #(
    parameter int DIVIDEND_W = SUM_W,
    parameter int DIVISOR_W  = CNT_W,
    parameter int QUOT_W     = COORD_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic [QUOT_W-1:0]     quotient,
    output logic                  done
);

    localparam int CW = $clog2(QUOT_W + 1);

    logic [DIVIDEND_W-1:0] rem, rem_in, rem_nx;
    logic [DIVIDEND_W-1:0] dsh, dsh_in;
    logic [QUOT_W-1:0]     q, q_in, q_nx;
    logic [CW-1:0]         left;
    logic                  run;
    logic                  ge;

    // The quotient is known to fit QUOT_W bits, so only the top QUOT_W
    // alignments of the divisor are tried; the first one runs on the start edge.
    always_comb begin
        rem_in = start ? dividend : rem;
        dsh_in = start ? (DIVIDEND_W'(divisor) << (QUOT_W - 1)) : dsh;
        q_in   = start ? '0 : q;
        ge     = (rem_in >= dsh_in);
        rem_nx = ge ? (rem_in - dsh_in) : rem_in;
        q_nx   = {q_in[QUOT_W-2:0], ge};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem  <= '0;
            dsh  <= '0;
            q    <= '0;
            left <= '0;
            run  <= 1'b0;
            done <= 1'b0;
        end else if (start || run) begin
            rem <= rem_nx;
            dsh <= dsh_in >> 1;
            q   <= q_nx;
            if (start) begin
                left <= CW'(QUOT_W - 1);
                run  <= 1'b1;
                done <= 1'b0;
            end else begin
                left <= left - CW'(1);
                if (left == CW'(1)) begin
                    run  <= 1'b0;
                    done <= 1'b1;
                end
            end
        end else begin
            done <= 1'b0;
        end
    end

    assign quotient = q;

endmodule

// File: rtl/centroid_updater.sv
// Accumulates per-cluster sums/counts per epoch, then emits floor(sum/count) per cluster.
// Latency: 1 cycle accumulate; 1+2*COORD_W cycles per non-empty centroid, 1 per empty one.
// Backpressure: pointReady low outside ACCUM; EMIT holds outputs until cenReady.
module centroid_updater import kmeans_pkg::*; (
    input  logic               clk,
    input  logic               rst_n,
    centroid_updater_if.slave  bus
);

    state_e             state;
    logic [SUM_W-1:0]   sum_x [N_CORES];
    logic [SUM_W-1:0]   sum_y [N_CORES];
    logic [CNT_W-1:0]   cnt   [N_CORES];
    logic [IDX_W-1:0]   idx;
    cen_t               cen;
    logic               err_onehot;
    logic               err_ovf;

    logic               accept;
    logic               hot_ok;
    logic [IDX_W-1:0]   sel;
    logic               cnt_full;
    logic               cnt_zero;

    logic               div_start;
    logic [SUM_W-1:0]   div_dividend;
    logic [COORD_W-1:0] div_q;
    logic               div_done;

    assign accept   = bus.pointValid && (state == ACCUM);
    assign hot_ok   = onehot_ok(bus.closestCore);
    assign sel      = onehot_enc(bus.closestCore);
    assign cnt_full = (cnt[sel] == {CNT_W{1'b1}});
    assign cnt_zero = (cnt[idx] == '0);

    // X divide launches from LOAD; Y launches in the cycle X completes.
    assign div_start    = ((state == LOAD) && !cnt_zero) || ((state == DIV_X) && div_done);
    assign div_dividend = (state == LOAD) ? sum_x[idx] : sum_y[idx];

    seq_divider #(
        .DIVIDEND_W (SUM_W),
        .DIVISOR_W  (CNT_W),
        .QUOT_W     (COORD_W)
    ) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (div_start),
        .dividend (div_dividend),
        .divisor  (cnt[idx]),
        .quotient (div_q),
        .done     (div_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_CORES; i++) begin
                sum_x[i] <= '0;
                sum_y[i] <= '0;
                cnt[i]   <= '0;
            end
        end else if (state == CLEAR) begin
            for (int i = 0; i < N_CORES; i++) begin
                sum_x[i] <= '0;
                sum_y[i] <= '0;
                cnt[i]   <= '0;
            end
        end else if (accept && hot_ok && !cnt_full) begin
            sum_x[sel] <= sum_x[sel] + SUM_W'(bus.pointX);
            sum_y[sel] <= sum_y[sel] + SUM_W'(bus.pointY);
            cnt[sel]   <= cnt[sel] + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_onehot <= 1'b0;
            err_ovf    <= 1'b0;
        end else begin
            if (accept && !hot_ok)            err_onehot <= 1'b1;
            if (accept && hot_ok && cnt_full) err_ovf    <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ACCUM;
            idx   <= '0;
            cen   <= '0;
        end else begin
            case (state)
                ACCUM: begin
                    if (bus.epochEnd) begin
                        state <= LOAD;
                        idx   <= '0;
                    end
                end
                LOAD: begin
                    if (cnt_zero) begin
                        cen   <= '{x: '0, y: '0, empty: 1'b1};
                        state <= EMIT;
                    end else begin
                        cen.empty <= 1'b0;
                        state     <= DIV_X;
                    end
                end
                DIV_X: begin
                    if (div_done) begin
                        cen.x <= div_q;
                        state <= DIV_Y;
                    end
                end
                DIV_Y: begin
                    if (div_done) begin
                        cen.y <= div_q;
                        state <= EMIT;
                    end
                end
                EMIT: begin
                    if (bus.cenReady) begin
                        if (idx == IDX_W'(N_CORES - 1)) begin
                            state <= CLEAR;
                        end else begin
                            idx   <= idx + IDX_W'(1);
                            state <= LOAD;
                        end
                    end
                end
                CLEAR: begin
                    state <= ACCUM;
                    idx   <= '0;
                end
                default: state <= ACCUM;
            endcase
        end
    end

    assign bus.pointReady = (state == ACCUM);
    assign bus.cenValid   = (state == EMIT);
    assign bus.busy       = (state != ACCUM);
    assign bus.cenIdx     = idx;
    assign bus.cenX       = cen.x;
    assign bus.cenY       = cen.y;
    assign bus.cenEmpty   = cen.empty;
    assign bus.errOneHot  = err_onehot;
    assign bus.errOvf     = err_ovf;

endmodule

// File: tb/tb_centroid_updater.sv
// Directed bench for centroid_updater: scoreboard queue filled by stimulus,
// drained by a monitor on every centroid handshake.
module tb_centroid_updater;

    logic clk;
    logic rst_n;

    centroid_updater_if bus ();

    centroid_updater dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int idx;
        int x;
        int y;
        bit empty;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Monitor: every accepted centroid must match the head of the expected queue.
    always @(negedge clk) begin
        if (rst_n && bus.cenValid && bus.cenReady) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL cen_unexpected: idx=%0d x=%0d y=%0d empty=%0d with nothing expected",
                         bus.cenIdx, bus.cenX, bus.cenY, bus.cenEmpty);
            end else begin
                mon_e = exp_q.pop_front();
                if (int'(bus.cenIdx) != mon_e.idx || int'(bus.cenX) != mon_e.x ||
                    int'(bus.cenY) != mon_e.y || bus.cenEmpty != mon_e.empty) begin
                    errors++;
                    $display("FAIL cen_out: got idx=%0d x=%0d y=%0d empty=%0d, expected idx=%0d x=%0d y=%0d empty=%0d",
                             bus.cenIdx, bus.cenX, bus.cenY, bus.cenEmpty,
                             mon_e.idx, mon_e.x, mon_e.y, mon_e.empty);
                end
            end
        end
    end

    // Expect clusters 0..last; only nz is non-empty with (x,y).
    task automatic push_epoch(input int nz, input int x, input int y, input int last);
        for (int i = 0; i <= last; i++) begin
            if (i == nz) exp_q.push_back('{idx: i, x: x, y: y, empty: 1'b0});
            else         exp_q.push_back('{idx: i, x: 0, y: 0, empty: 1'b1});
        end
    endtask

    task automatic send_point(input int x, input int y, input logic [15:0] cc, input bit ep);
        bus.pointValid  = 1'b1;
        bus.pointX      = 8'(x);
        bus.pointY      = 8'(y);
        bus.closestCore = cc;
        bus.epochEnd    = ep;
        @(posedge clk); #1;
        bus.pointValid  = 1'b0;
        bus.epochEnd    = 1'b0;
    endtask

    task automatic epoch_pulse();
        bus.epochEnd = 1'b1;
        @(posedge clk); #1;
        bus.epochEnd = 1'b0;
    endtask

    // Takes n_hs centroids; holds cenReady low for 5 cycles on cluster bp_idx.
    task automatic drain(input int n_hs, input int bp_idx, input int bx, input int by,
                         output int first_wait);
        int hs;
        int waited;
        hs = 0;
        waited = 0;
        first_wait = -1;
        while (hs < n_hs && waited < 3000) begin
            if (bus.cenValid) begin
                if (first_wait < 0) first_wait = waited;
                if (int'(bus.cenIdx) == bp_idx) begin
                    bus.cenReady = 1'b0;
                    for (int i = 0; i < 5; i++) begin
                        @(posedge clk); #1;
                        chk("bp_valid", 32'(bus.cenValid), 1);
                        chk("bp_idx",   32'(bus.cenIdx), bp_idx);
                        chk("bp_x",     32'(bus.cenX), bx);
                        chk("bp_y",     32'(bus.cenY), by);
                    end
                    bp_idx = -1;
                end
                bus.cenReady = 1'b1;
                @(posedge clk); #1;
                bus.cenReady = 1'b0;
                hs++;
            end else begin
                @(posedge clk); #1;
                waited++;
            end
        end
        if (hs < n_hs) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d handshakes, expected %0d", hs, n_hs);
        end
    endtask

    // Called right after the last handshake: one CLEAR cycle, then ACCUM.
    task automatic finish_epoch();
        chk("queue_empty", 32'(exp_q.size()), 0);
        chk("clear_busy", 32'(bus.busy), 1);
        chk("clear_point_ready", 32'(bus.pointReady), 0);
        @(posedge clk); #1;
        chk("accum_point_ready", 32'(bus.pointReady), 1);
        chk("accum_busy", 32'(bus.busy), 0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_point_ready"}, 32'(bus.pointReady), 1);
        chk({tag, "_cen_valid"},   32'(bus.cenValid), 0);
        chk({tag, "_busy"},        32'(bus.busy), 0);
        chk({tag, "_err_onehot"},  32'(bus.errOneHot), 0);
        chk({tag, "_err_ovf"},     32'(bus.errOvf), 0);
        chk({tag, "_cen_idx"},     32'(bus.cenIdx), 0);
        chk({tag, "_cen_x"},       32'(bus.cenX), 0);
        chk({tag, "_cen_y"},       32'(bus.cenY), 0);
        chk({tag, "_cen_empty"},   32'(bus.cenEmpty), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int fw;
        rst_n           = 1'b0;
        bus.pointValid  = 1'b0;
        bus.pointX      = '0;
        bus.pointY      = '0;
        bus.closestCore = '0;
        bus.epochEnd    = 1'b0;
        bus.cenReady    = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk_reset_vals("por");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Partial stream into cluster 2 plus a bad point, then reset wipes it.
        send_point(100, 100, 16'h0004, 1'b0);
        send_point(100, 100, 16'h0004, 1'b0);
        send_point(1, 1, 16'h0003, 1'b0);
        chk("pre_reset_err_onehot", 32'(bus.errOneHot), 1);
        rst_n = 1'b0;
        #1;
        chk_reset_vals("mid_rst");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic means with backpressure on cluster 2: (61,121)/3 = (20,40).
        send_point(10, 20, 16'h0004, 1'b0);
        send_point(20, 40, 16'h0004, 1'b0);
        send_point(31, 61, 16'h0004, 1'b0);
        epoch_pulse();
        chk("epoch_busy", 32'(bus.busy), 1);
        chk("epoch_point_ready", 32'(bus.pointReady), 0);
        push_epoch(2, 20, 40, 15);
        drain(16, 2, 20, 40, fw);
        chk("empty_latency", 32'(fw), 1);
        finish_epoch();

        // Bad one-hot points are dropped; only cluster 7 gets data.
        send_point(5, 5, 16'h0005, 1'b0);
        chk("err_onehot_multi", 32'(bus.errOneHot), 1);
        send_point(6, 6, 16'h0000, 1'b0);
        chk("err_onehot_zero", 32'(bus.errOneHot), 1);
        send_point(100, 50, 16'h0080, 1'b0);
        epoch_pulse();
        push_epoch(7, 100, 50, 15);
        drain(16, -1, 0, 0, fw);
        finish_epoch();

        // Point coincident with epochEnd is included; points offered while busy are not.
        send_point(255, 255, 16'h0001, 1'b1);
        bus.pointValid  = 1'b1;
        bus.pointX      = 8'd1;
        bus.pointY      = 8'd1;
        bus.closestCore = 16'h0001;
        chk("busy_point_ready", 32'(bus.pointReady), 0);
        push_epoch(0, 255, 255, 15);
        drain(16, -1, 0, 0, fw);
        bus.pointValid = 1'b0;
        chk("nonempty_latency", 32'(fw), 17);
        chk("sticky_err_onehot", 32'(bus.errOneHot), 1);
        chk("err_ovf_clear", 32'(bus.errOvf), 0);
        finish_epoch();

        // Reset during DIV_Y of cluster 5.
        send_point(40, 80, 16'h0020, 1'b0);
        send_point(60, 100, 16'h0020, 1'b0);
        epoch_pulse();
        push_epoch(-1, 0, 0, 4);
        drain(5, -1, 0, 0, fw);
        chk("load5_idx", 32'(bus.cenIdx), 5);
        chk("load5_busy", 32'(bus.busy), 1);
        repeat (12) @(posedge clk);
        #1;
        chk("divy_cen_valid", 32'(bus.cenValid), 0);
        rst_n = 1'b0;
        #1;
        chk_reset_vals("divy_rst");
        chk("divy_queue_empty", 32'(exp_q.size()), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Fresh epoch: cluster 5 must be empty, cluster 3 = (9,5)/2 = (4,2).
        send_point(9, 4, 16'h0008, 1'b0);
        send_point(0, 1, 16'h0008, 1'b0);
        epoch_pulse();
        push_epoch(3, 4, 2, 15);
        drain(16, -1, 0, 0, fw);
        finish_epoch();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
